// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - shared constants, FSM encodings and index-width helper for bus_controller
package bus_ctrl_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 8;
  localparam int DEF_TURN_CYC = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_TURN  = 2'd3;

  // Width of an agent index; a single agent still needs one bit to be addressable.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin selector: first asserted request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);

  int j;

  always_comb begin
    j     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[W'(j)]) begin
        valid = 1'b1;
        grant = N'(1) << j;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_controller.sv
// rtl/bus_controller.sv - shared tristate bus arbiter: grant, settle, load, turnaround
module bus_controller
  import bus_ctrl_pkg::*;
#(
  parameter  int N_REQ    = DEF_N_REQ,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  parameter  int TURN_CYC = DEF_TURN_CYC,
  localparam int W        = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ*W-1:0] req_dst,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] oe,
  output logic [N_REQ-1:0] ld,
  output logic             busy,
  output logic             err
);

  logic [1:0]       state, state_n;
  logic [W-1:0]     ptr, ptr_n, src, src_n, dst, dst_n;
  logic [7:0]       hold, hold_n;
  logic [3:0]       turn, turn_n;
  logic [N_REQ-1:0] gnt_n, oe_n, ld_n;
  logic             err_n;
  logic [N_REQ-1:0] win_oh, src_oh, dst_oh;
  logic [W-1:0]     win_idx, win_dst;
  logic             win_valid;
  logic [W-1:0]     dst_f [N_REQ];

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_fld
      assign dst_f[g] = req_dst[g*W +: W];
    end
  endgenerate

  assign win_dst = dst_f[win_idx];
  assign src_oh  = N_REQ'(1) << src;
  assign dst_oh  = N_REQ'(1) << dst;

  rr_arbiter #(.N(N_REQ), .W(W)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (win_oh),
    .idx   (win_idx),
    .valid (win_valid)
  );

  function automatic logic [W-1:0] next_idx(input logic [W-1:0] x);
    return (int'(x) >= N_REQ - 1) ? '0 : x + W'(1);
  endfunction

  // Next-cycle values are computed here so every output leaves a flop.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    src_n   = src;
    dst_n   = dst;
    hold_n  = hold;
    turn_n  = turn;
    gnt_n   = '0;
    oe_n    = '0;
    ld_n    = '0;
    err_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          if (win_dst == win_idx) begin
            err_n = 1'b1;
            ptr_n = next_idx(win_idx);
          end else begin
            src_n   = win_idx;
            dst_n   = win_dst;
            state_n = ST_GRANT;
            gnt_n   = win_oh;
            oe_n    = win_oh;
          end
        end
      end
      ST_GRANT: begin
        if (req[src]) begin
          state_n = ST_XFER;
          hold_n  = '0;
          gnt_n   = src_oh;
          oe_n    = src_oh;
          ld_n    = dst_oh;
        end else begin
          state_n = ST_TURN;
          turn_n  = '0;
          ptr_n   = next_idx(src);
        end
      end
      ST_XFER: begin
        // hold counts loads already completed before the current one
        if (req[src] && (int'(hold) + 1 < MAX_HOLD)) begin
          hold_n = hold + 8'd1;
          gnt_n  = src_oh;
          oe_n   = src_oh;
          ld_n   = dst_oh;
        end else begin
          state_n = ST_TURN;
          turn_n  = '0;
          ptr_n   = next_idx(src);
        end
      end
      default: begin
        if (int'(turn) + 1 >= TURN_CYC) state_n = ST_IDLE;
        else                            turn_n  = turn + 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      src   <= '0;
      dst   <= '0;
      hold  <= '0;
      turn  <= '0;
      gnt   <= '0;
      oe    <= '0;
      ld    <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      src   <= src_n;
      dst   <= dst_n;
      hold  <= hold_n;
      turn  <= turn_n;
      gnt   <= gnt_n;
      oe    <= oe_n;
      ld    <= ld_n;
      busy  <= (state_n != ST_IDLE);
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
// tb/tb_bus_controller.sv - randomized and directed bench for bus_controller against an ownership model
module tb_bus_controller;

  localparam int N    = 4;
  localparam int MAXH = 8;
  localparam int TC   = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] req_dst = '0;
  logic [3:0] gnt, oe, ld;
  logic       busy, err;

  int vectors = 0;
  int miscompares = 0;

  bus_controller #(.N_REQ(N), .MAX_HOLD(MAXH), .TURN_CYC(TC)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_dst (req_dst),
    .gnt     (gnt),
    .oe      (oe),
    .ld      (ld),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic int fld(input logic [7:0] v, input int i);
    return int'((v >> (2 * i)) & 8'h3);
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Bus ownership model: who owns the bus, whether the bus is still settling,
  // how many loads have happened, and how many quiet cycles remain.
  int m_owner = -1, m_dst = 0, m_loads = 0, m_turn = 0, m_ptr = 0, m_j = 0;
  bit m_settle = 0, m_err = 0, m_live = 0, m_found = 0;

  task automatic m_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_turn  = TC;
  endtask

  always @(posedge clk) begin
    m_err = 0;
    if (reset) begin
      m_owner = -1; m_turn = 0; m_ptr = 0; m_settle = 0; m_loads = 0;
    end else if (m_turn > 0) begin
      m_turn--;
    end else if (m_owner < 0) begin
      m_found = 0;
      for (int k = 0; k < N; k++) begin
        m_j = (m_ptr + k) % N;
        if (!m_found && req[m_j]) begin
          m_found = 1;
          if (fld(req_dst, m_j) == m_j) begin
            m_err = 1;
            m_ptr = (m_j + 1) % N;
          end else begin
            m_owner = m_j; m_dst = fld(req_dst, m_j); m_settle = 1;
          end
        end
      end
    end else if (m_settle) begin
      m_settle = 0;
      if (req[m_owner]) m_loads = 1;
      else m_release();
    end else if (req[m_owner] && m_loads < MAXH) begin
      m_loads++;
    end else begin
      m_release();
    end
    m_live = 1;
  end

  logic [3:0] prev_oe = '0;
  logic [3:0] e_oe, e_ld;

  always @(negedge clk) begin
    if (m_live) begin
      e_oe = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
      e_ld = (m_owner >= 0 && !m_settle) ? 4'(1 << m_dst) : 4'd0;
      chk("gnt", 32'(gnt), 32'(e_oe));
      chk("oe", 32'(oe), 32'(e_oe));
      chk("ld", 32'(ld), 32'(e_ld));
      chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_turn > 0)));
      chk("err", 32'(err), 32'(m_err));
      chk("ptr", 32'(dut.ptr), 32'(m_ptr));
      chk("oe_onehot", 32'($countones(oe) <= 1), 32'd1);
      chk("oe_turnaround", 32'(!(prev_oe != 0 && oe != 0 && oe != prev_oe)), 32'd1);
      prev_oe = oe;
    end
  end

  int order[$];
  int ldc[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int cur_ld, n, extra;
  logic [3:0] pg;

  initial begin
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;

    // single request: agent 1 -> agent 3
    req_dst = 8'h0C;
    req = 4'b0010;
    tick();
    chk("single_gnt", 32'(gnt), 32'h2);
    chk("single_oe", 32'(oe), 32'h2);
    chk("single_ld_settle", 32'(ld), 32'h0);
    tick();
    chk("single_ld", 32'(ld), 32'h8);
    chk("single_oe_x", 32'(oe), 32'h2);
    repeat (2) tick();
    req = 4'b0000;
    tick();
    chk("single_turn_oe", 32'(oe), 32'h0);
    chk("single_turn_ld", 32'(ld), 32'h0);
    chk("single_turn_busy", 32'(busy), 32'h1);
    tick();
    chk("single_idle_busy", 32'(busy), 32'h0);

    // fairness: everyone requests, everyone targets the next agent
    do_reset();
    req_dst = 8'h39;
    req = 4'b1111;
    pg = '0;
    cur_ld = 0;
    for (int c = 0; c < 150 && order.size() < 5; c++) begin
      tick();
      if (gnt != 0 && pg == 0) begin
        order.push_back(oh2i(gnt));
        cur_ld = 0;
      end
      if (ld != 0) cur_ld++;
      if (gnt == 0 && pg != 0) ldc.push_back(cur_ld);
      pg = gnt;
    end
    chk("fair_grants", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < order.size()) chk("fair_order", 32'(order[i]), 32'(exp_order[i]));
    chk("fair_ldc_n", 32'(ldc.size()), 32'd4);
    for (int i = 0; i < ldc.size(); i++) chk("fair_ld_cycles", 32'(ldc[i]), 32'd8);
    req = '0;
    repeat (12) tick();

    // early drop after 3 loads by agent 2
    do_reset();
    req_dst = 8'h39;
    req = 4'b0100;
    n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      tick();
      if (ld != 0) begin
        n++;
        chk("drop_ld_val", 32'(ld), 32'h8);
      end
    end
    req = '0;
    chk("drop_count", 32'(n), 32'd3);
    tick();
    chk("drop_turn_ld", 32'(ld), 32'h0);
    chk("drop_turn_gnt", 32'(gnt), 32'h0);
    extra = 0;
    repeat (4) begin
      tick();
      if (ld != 0) extra++;
    end
    chk("drop_extra", 32'(extra), 32'd0);
    chk("drop_ptr", 32'(dut.ptr), 32'd3);

    // self-target rejected, pending agent 1 wins next
    do_reset();
    req_dst = 8'h08;
    req = 4'b0011;
    tick();
    chk("self_err", 32'(err), 32'h1);
    chk("self_gnt", 32'(gnt), 32'h0);
    chk("self_oe", 32'(oe), 32'h0);
    tick();
    chk("self_next_gnt", 32'(gnt), 32'h2);
    chk("self_err_clr", 32'(err), 32'h0);
    req = '0;
    repeat (4) tick();

    // reset during the 4th load
    do_reset();
    req_dst = 8'h39;
    req = 4'b0001;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      tick();
      if (ld != 0) n++;
    end
    chk("rstx_loads", 32'(n), 32'd4);
    reset = 1'b1;
    tick();
    chk("rstx_oe", 32'(oe), 32'h0);
    chk("rstx_ld", 32'(ld), 32'h0);
    chk("rstx_gnt", 32'(gnt), 32'h0);
    chk("rstx_busy", 32'(busy), 32'h0);
    chk("rstx_ptr", 32'(dut.ptr), 32'h0);
    reset = 1'b0;
    req = '0;

    // randomized traffic, including self-targets and stray resets
    for (int c = 0; c < 800; c++) begin
      tick();
      reset = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 25) req = 4'($urandom);
      if ($urandom_range(0, 99) < 15) req_dst = 8'($urandom);
    end
    reset = 1'b0;
    req = '0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
